mod_n_pwm: RTL and testbench

- Downstream consumer of the mod-N counter's count bus. Turns the free-running 0..N-1 count into a registered PWM waveform with a programmable duty.
- Duty updates are glitch-free: a shadow register is applied only at period wrap.
- Flags one tick per period and checks count-sequence integrity, so counter faults are caught at the consumer.

---
 rtl/mod_n_pkg.sv | 19 +
 rtl/mod_n_pwm_if.sv | 23 ++
 rtl/mod_n_seq_check.sv | 18 +
 rtl/mod_n_pwm.sv | 99 +++++++++
 tb/tb_mod_n_pwm.sv | 139 +++++++++++++
 5 files changed

// File: rtl/mod_n_pkg.sv
// rtl/mod_n_pkg.sv - shared state encoding and count/duty helpers for the mod-N PWM consumer
package mod_n_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    function automatic int clamp_duty(input int duty, input int n);
        return (duty > n) ? n : duty;
    endfunction

    // Same modular increment the upstream counter uses.
    function automatic int next_count(input int c, input int n);
        return (c == n - 1) ? 0 : c + 1;
    endfunction

endpackage

// File: rtl/mod_n_pwm_if.sv
// rtl/mod_n_pwm_if.sv - count bus, duty control and PWM status bundle
interface mod_n_pwm_if #(
    parameter int LENGTH = 3
);
    logic [LENGTH-1:0] count_in;
    logic              en;
    logic [LENGTH:0]   duty_in;
    logic              duty_load;
    logic              pwm_out;
    logic              period_tick;
    logic              seq_err;
    logic [1:0]        state_o;

    modport master (
        output count_in, en, duty_in, duty_load,
        input  pwm_out, period_tick, seq_err, state_o
    );

    modport slave (
        input  count_in, en, duty_in, duty_load,
        output pwm_out, period_tick, seq_err, state_o
    );
endinterface

// File: rtl/mod_n_seq_check.sv
// rtl/mod_n_seq_check.sv - wrap detection and count-sequence mismatch against the previous count
module mod_n_seq_check
    import mod_n_pkg::*;
#(
    parameter int N      = 6,
    parameter int LENGTH = 3
) (
    input  logic [LENGTH-1:0] count_in,
    input  logic [LENGTH-1:0] prev_count,
    output logic              wrap,
    output logic              mismatch
);
    always_comb begin
        wrap     = (int'(count_in) == 0) && (int'(prev_count) == N - 1);
        mismatch = (int'(count_in) >= N) ||
                   (int'(count_in) != next_count(int'(prev_count), N));
    end
endmodule

// File: rtl/mod_n_pwm.sv
// rtl/mod_n_pwm.sv - registered PWM driven by a mod-N count bus, with wrap-aligned duty update
module mod_n_pwm
    import mod_n_pkg::*;
#(
    parameter int N      = 6,
    parameter int LENGTH = 3
) (
    input  logic        clk,
    input  logic        reset,
    mod_n_pwm_if.slave  bus
);
    localparam int DW = LENGTH + 1;

    state_t            state, state_nx;
    logic [LENGTH-1:0] prev_count;
    logic [DW-1:0]     duty_pend, duty_pend_nx;
    logic [DW-1:0]     duty_act, duty_act_nx;
    logic [DW-1:0]     duty_clamp, duty_new, duty_eff;
    logic              pwm_q, pwm_nx;
    logic              tick_q, tick_nx;
    logic              err_q, err_nx;
    logic              apply, run_cmp;
    logic              wrap, mismatch;

    mod_n_seq_check #(.N(N), .LENGTH(LENGTH)) u_seq_check (
        .count_in   (bus.count_in),
        .prev_count (prev_count),
        .wrap       (wrap),
        .mismatch   (mismatch)
    );

    always_comb begin
        duty_clamp   = DW'(clamp_duty(int'(bus.duty_in), N));
        // A load landing on the apply cycle bypasses the pending register.
        duty_new     = bus.duty_load ? duty_clamp : duty_pend;
        duty_pend_nx = duty_new;
        state_nx     = state;
        err_nx       = err_q;
        apply        = 1'b0;
        run_cmp      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.en) state_nx = SYNC;
            end
            SYNC: begin
                if (!bus.en) begin
                    state_nx = IDLE;
                end else if (bus.count_in == '0) begin
                    apply    = 1'b1;
                    run_cmp  = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (mismatch) err_nx = 1'b1;
                if (!bus.en) begin
                    state_nx = IDLE;
                end else if (mismatch) begin
                    state_nx = SYNC;
                end else begin
                    apply   = wrap;
                    run_cmp = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        duty_eff    = apply ? duty_new : duty_act;
        duty_act_nx = duty_eff;
        tick_nx     = apply;
        pwm_nx      = run_cmp && ({1'b0, bus.count_in} < duty_eff);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            prev_count <= '0;
            duty_pend  <= '0;
            duty_act   <= '0;
            pwm_q      <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nx;
            prev_count <= bus.count_in;
            duty_pend  <= duty_pend_nx;
            duty_act   <= duty_act_nx;
            pwm_q      <= pwm_nx;
            tick_q     <= tick_nx;
            err_q      <= err_nx;
        end
    end

    assign bus.pwm_out     = pwm_q;
    assign bus.period_tick = tick_q;
    assign bus.seq_err     = err_q;
    assign bus.state_o     = state;
endmodule

// File: tb/tb_mod_n_pwm.sv
// tb/tb_mod_n_pwm.sv - directed vector bench for mod_n_pwm (N=6, LENGTH=3)
module tb_mod_n_pwm;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mod_n_pwm_if #(.LENGTH(3)) bus ();

    mod_n_pwm #(.N(6), .LENGTH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0] c;
        logic       e;
        logic       dl;
        logic [3:0] din;
        logic       pwm;
        logic       tick;
        logic       err;
        logic [1:0] st;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0d want=%0d", name, idx, act, exp);
        end
    endtask

    task automatic add(input int c, input int e, input int dl, input int din,
                       input int pwm, input int tick, input int err, input int st);
        vec_t v;
        v.c = 3'(c); v.e = 1'(e); v.dl = 1'(dl); v.din = 4'(din);
        v.pwm = 1'(pwm); v.tick = 1'(tick); v.err = 1'(err); v.st = 2'(st);
        vq.push_back(v);
    endtask

    // One clean RUN period; optional duty_load at count ld_at.
    task automatic add_period(input int duty, input int ld_at, input int din, input int err);
        for (int c = 0; c < 6; c++)
            add(c, 1, (c == ld_at) ? 1 : 0, din, (c < duty) ? 1 : 0, (c == 0) ? 1 : 0, err, 2);
    endtask

    task automatic step(input int c, input int e, input int dl, input int din);
        bus.count_in  = 3'(c);
        bus.en        = 1'(e);
        bus.duty_load = 1'(dl);
        bus.duty_in   = 4'(din);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int pwm, input int tick, input int err, input int st);
        chk({tag, "_pwm"},   0, 4'(bus.pwm_out),     4'(pwm));
        chk({tag, "_tick"},  0, 4'(bus.period_tick), 4'(tick));
        chk({tag, "_err"},   0, 4'(bus.seq_err),     4'(err));
        chk({tag, "_state"}, 0, 4'(bus.state_o),     4'(st));
    endtask

    initial begin
        // start-up into SYNC, duty 2 loaded while idle
        add(3, 1, 1, 2, 0, 0, 0, 1);
        add(4, 1, 0, 0, 0, 0, 0, 1);
        add(5, 1, 0, 0, 0, 0, 0, 1);
        add_period(2, -1, 0, 0);
        add_period(2, -1, 0, 0);
        // mid-period load of 4 takes effect next period
        add_period(2, 3, 4, 0);
        add_period(4, 2, 0, 0);
        // boundary duties: 0, 7 (clamped to 6), 6
        add_period(0, 3, 7, 0);
        add_period(6, 3, 6, 0);
        add_period(6, -1, 0, 0);
        // load on the wrap cycle applies in the same period and sticks
        add_period(5, 0, 5, 0);
        add_period(5, -1, 0, 0);
        // broken sequence 0,1,2,4
        add(0, 1, 0, 0, 1, 1, 0, 2);
        add(1, 1, 0, 0, 1, 0, 0, 2);
        add(2, 1, 0, 0, 1, 0, 0, 2);
        add(4, 1, 0, 0, 0, 0, 1, 1);
        add(5, 1, 0, 0, 0, 0, 1, 1);
        add_period(5, -1, 0, 1);
        // enable drop and re-sync
        add(0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 1, 0, 0, 0, 0, 1, 1);
        add(2, 1, 0, 0, 0, 0, 1, 1);
        add(3, 1, 0, 0, 0, 0, 1, 1);
        add(4, 1, 0, 0, 0, 0, 1, 1);
        add(5, 1, 0, 0, 0, 0, 1, 1);
        add_period(5, -1, 0, 1);

        reset = 1'b0;
        bus.count_in = '0; bus.en = 1'b0; bus.duty_in = '0; bus.duty_load = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk_out("reset", 0, 0, 0, 0);
        reset = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].c, vq[i].e, vq[i].dl, vq[i].din);
            chk("pwm",   i, 4'(bus.pwm_out),     4'(vq[i].pwm));
            chk("tick",  i, 4'(bus.period_tick), 4'(vq[i].tick));
            chk("err",   i, 4'(bus.seq_err),     4'(vq[i].err));
            chk("state", i, 4'(bus.state_o),     4'(vq[i].st));
        end

        // async reset while pwm_out is high at count 1
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk_out("pre_rst", 1, 0, 1, 2);
        #2 reset = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        step(2, 1, 0, 0);
        chk_out("post_idle", 0, 0, 0, 1);
        step(3, 1, 0, 0);
        step(4, 1, 0, 0);
        step(5, 1, 0, 0);
        chk_out("post_sync", 0, 0, 0, 1);
        step(0, 1, 0, 0);
        chk_out("post_run0", 0, 1, 0, 2);
        step(1, 1, 0, 0);
        chk_out("post_run1", 0, 0, 0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
